// File: rtl/hash_req_packer.sv
// Request-side packer for hash_func_pipe: collects a byte stream into one wide request,
// holds the pipe when the result FIFO is nearly full, and buffers returned keys.
module hash_req_packer #(
  parameter int unsigned DATA_BYTES     = 52,
  parameter int unsigned LEN_W          = 32,
  parameter int unsigned KEY_W          = 16,
  parameter int unsigned KEY_FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [7:0]              s_byte,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic [8*DATA_BYTES-1:0] o_data,
  output logic [LEN_W-1:0]        o_length,
  output logic                    o_start,
  output logic                    o_stall_pipe,
  input  logic [KEY_W-1:0]        i_hash_key,
  input  logic                    i_valid,
  output logic [KEY_W-1:0]        m_key,
  output logic                    m_key_valid,
  input  logic                    m_key_ready,
  output logic                    o_trunc,
  output logic                    o_overflow
);

  localparam int unsigned DataW  = 8 * DATA_BYTES;
  localparam int unsigned CntW   = $clog2(DATA_BYTES + 1);
  localparam int unsigned PtrW   = $clog2(KEY_FIFO_DEPTH);
  localparam int unsigned FcntW  = PtrW + 1;

  localparam logic [CntW-1:0]  MaxCnt   = CntW'(DATA_BYTES);
  localparam logic [FcntW-1:0] FifoFull = FcntW'(KEY_FIFO_DEPTH);
  localparam logic [FcntW-1:0] FifoHigh = FcntW'(KEY_FIFO_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StFill, StIssue} state_e;

  state_e            state_q;
  logic [DataW-1:0]  buf_q;
  logic [CntW-1:0]   byte_cnt_q;
  logic              trunc_q;
  logic              stall_q;
  logic              overflow_q;

  logic [KEY_W-1:0]  mem_q [KEY_FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [FcntW-1:0]  fcnt_q;

  logic              accept;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic [31:0]       wr_pos;

  assign s_ready  = (state_q != StIssue);
  assign accept   = s_valid && s_ready;
  assign o_start  = (state_q == StIssue) && !stall_q;
  assign o_data   = buf_q;
  assign o_length = LEN_W'(byte_cnt_q);
  assign o_trunc  = trunc_q;
  assign o_stall_pipe = stall_q;
  assign o_overflow   = overflow_q;

  // Byte k lands at the top of the buffer first (MSB-first packing).
  assign wr_pos = 32'(DATA_BYTES - 1) - 32'(byte_cnt_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      buf_q      <= '0;
      byte_cnt_q <= '0;
      trunc_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StFill: begin
          if (accept) begin
            if (byte_cnt_q < MaxCnt) begin
              buf_q[8*wr_pos +: 8] <= s_byte;
              byte_cnt_q           <= byte_cnt_q + 1'b1;
            end else begin
              trunc_q <= 1'b1;
            end
            state_q <= s_last ? StIssue : StFill;
          end
        end
        StIssue: begin
          if (o_start) begin
            buf_q      <= '0;
            byte_cnt_q <= '0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Result FIFO: a full FIFO still takes a push when the head is popped in the same cycle.
  assign fifo_full   = (fcnt_q == FifoFull);
  assign fifo_pop    = (fcnt_q != '0) && m_key_ready;
  assign fifo_push   = i_valid && (!fifo_full || fifo_pop);
  assign m_key_valid = (fcnt_q != '0);
  assign m_key       = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(KEY_FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (fifo_push) begin
        mem_q[wr_ptr_q] <= i_hash_key;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({fifo_push, fifo_pop})
        2'b10:   fcnt_q <= fcnt_q + 1'b1;
        2'b01:   fcnt_q <= fcnt_q - 1'b1;
        default: fcnt_q <= fcnt_q;
      endcase
      if (i_valid && fifo_full && !fifo_pop) begin
        overflow_q <= 1'b1;
      end
      // One spare slot absorbs a result already in flight when the stall lands.
      stall_q <= (fcnt_q >= FifoHigh);
    end
  end

endmodule

// File: tb/tb_hash_req_packer.sv
// Self-checking bench for hash_req_packer: directed scenarios plus a random phase, all
// compared every cycle against a message/queue-level reference model.
module tb_hash_req_packer;

  localparam int DB = 52;
  localparam int DW = 8 * DB;

  typedef logic [7:0] byte_q_t [$];

  logic            clk = 1'b0;
  logic            rstn;
  logic [7:0]      s_byte;
  logic            s_valid;
  logic            s_last;
  logic            s_ready;
  logic [DW-1:0]   o_data;
  logic [31:0]     o_length;
  logic            o_start;
  logic            o_stall_pipe;
  logic [15:0]     i_hash_key;
  logic            i_valid;
  logic [15:0]     m_key;
  logic            m_key_valid;
  logic            m_key_ready;
  logic            o_trunc;
  logic            o_overflow;

  hash_req_packer dut (
    .clk          (clk),
    .rstn         (rstn),
    .s_byte       (s_byte),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .o_data       (o_data),
    .o_length     (o_length),
    .o_start      (o_start),
    .o_stall_pipe (o_stall_pipe),
    .i_hash_key   (i_hash_key),
    .i_valid      (i_valid),
    .m_key        (m_key),
    .m_key_valid  (m_key_valid),
    .m_key_ready  (m_key_ready),
    .o_trunc      (o_trunc),
    .o_overflow   (o_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: message being collected, message awaiting issue, key queue.
  logic [DW-1:0] cur_vec;
  int            cur_len;
  logic [DW-1:0] pend_vec;
  int            pend_len;
  bit            pending;
  bit            trunc_m;
  bit            ovf_m;
  bit            stall_m;
  logic [15:0]   fq [$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur_vec  = '0;
    cur_len  = 0;
    pend_vec = '0;
    pend_len = 0;
    pending  = 1'b0;
    trunc_m  = 1'b0;
    ovf_m    = 1'b0;
    stall_m  = 1'b0;
    fq.delete();
  endtask

  task automatic check_all();
    chk("s_ready", DW'(s_ready), DW'(!pending));
    chk("o_start", DW'(o_start), DW'(pending && !stall_m));
    chk("o_data", o_data, pending ? pend_vec : cur_vec);
    chk("o_length", DW'(o_length), DW'(pending ? pend_len : cur_len));
    chk("o_stall_pipe", DW'(o_stall_pipe), DW'(stall_m));
    chk("o_trunc", DW'(o_trunc), DW'(trunc_m));
    chk("o_overflow", DW'(o_overflow), DW'(ovf_m));
    chk("m_key_valid", DW'(m_key_valid), DW'(fq.size() != 0));
    if (fq.size() != 0) chk("m_key", DW'(m_key), DW'(fq[0]));
  endtask

  // Called at a negedge: check outputs, drive inputs, advance model across the next posedge.
  task automatic step(input bit sv, input logic [7:0] sb, input bit sl,
                      input bit iv, input logic [15:0] key, input bit mr);
    bit started;
    bit pop;
    int sz;
    check_all();
    s_valid     = sv;
    s_byte      = sb;
    s_last      = sl;
    i_valid     = iv;
    i_hash_key  = key;
    m_key_ready = mr;
    started = pending && !stall_m;
    sz      = fq.size();
    if (started) begin
      pending  = 1'b0;
      pend_vec = '0;
      pend_len = 0;
    end else if (sv && !pending) begin
      if (cur_len < DB) begin
        cur_vec[DW-1-8*cur_len -: 8] = sb;
        cur_len++;
      end else begin
        trunc_m = 1'b1;
      end
      if (sl) begin
        pending  = 1'b1;
        pend_vec = cur_vec;
        pend_len = cur_len;
        cur_vec  = '0;
        cur_len  = 0;
      end
    end
    pop     = mr && (sz > 0);
    stall_m = (sz >= 7);
    if (pop) void'(fq.pop_front());
    if (iv) begin
      if (sz < 8 || pop) fq.push_back(key);
      else ovf_m = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit mr);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 16'h0, mr);
  endtask

  task automatic send(input byte_q_t b, input bit mr);
    for (int i = 0; i < b.size(); i++) begin
      for (int w = 0; w < 40 && pending; w++) step(1'b0, 8'h00, 1'b0, 1'b0, 16'h0, mr);
      step(1'b1, b[i], i == b.size() - 1, 1'b0, 16'h0, mr);
    end
  endtask

  task automatic do_reset(input int n);
    rstn        = 1'b0;
    s_valid     = 1'b0;
    s_byte      = 8'h00;
    s_last      = 1'b0;
    i_valid     = 1'b0;
    i_hash_key  = 16'h0;
    m_key_ready = 1'b0;
    #1;
    chk("rst_o_data", o_data, '0);
    chk("rst_o_length", DW'(o_length), '0);
    chk("rst_o_start", DW'(o_start), '0);
    chk("rst_o_stall", DW'(o_stall_pipe), '0);
    chk("rst_m_key_valid", DW'(m_key_valid), '0);
    chk("rst_m_key", DW'(m_key), '0);
    chk("rst_o_trunc", DW'(o_trunc), '0);
    chk("rst_o_overflow", DW'(o_overflow), '0);
    model_reset();
    for (int i = 0; i < n; i++) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    byte_q_t     msg;
    logic [DW-1:0] gt_exp;
    logic [DW-1:0] good_exp;
    gt_exp   = {72'h476f6f642074696d65, 344'h0};
    good_exp = {32'h476f6f64, 384'h0};

    @(negedge clk);
    do_reset(2);
    idle(2, 1'b1);

    // "Good time": request visible the cycle after the last byte.
    msg = '{8'h47, 8'h6f, 8'h6f, 8'h64, 8'h20, 8'h74, 8'h69, 8'h6d, 8'h65};
    send(msg, 1'b1);
    chk("gt_start", DW'(o_start), DW'(1));
    chk("gt_data", o_data, gt_exp);
    chk("gt_length", DW'(o_length), DW'(9));
    idle(3, 1'b1);

    // 60-byte message truncates to 52.
    msg.delete();
    for (int i = 0; i < 60; i++) msg.push_back(8'($urandom));
    send(msg, 1'b1);
    chk("trunc_len", DW'(o_length), DW'(52));
    chk("trunc_flag", DW'(o_trunc), DW'(1));
    idle(3, 1'b1);

    // Seven held results raise the stall; a pending request waits until one pop.
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 16'(i), 1'b0);
    idle(1, 1'b0);
    chk("stall_high", DW'(o_stall_pipe), DW'(1));
    msg = '{8'($urandom), 8'($urandom), 8'($urandom)};
    send(msg, 1'b0);
    idle(5, 1'b0);
    idle(1, 1'b1);
    idle(12, 1'b1);

    // Full FIFO: push+pop keeps 8, push without pop overflows.
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 16'(i), 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 16'h0008, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 16'h0009, 1'b0);
    chk("ovf_flag", DW'(o_overflow), DW'(1));
    idle(12, 1'b1);

    // Back-to-back "Good" messages.
    msg = '{8'h47, 8'h6f, 8'h6f, 8'h64};
    for (int r = 0; r < 3; r++) begin
      send(msg, 1'b1);
      chk("good_data", o_data, good_exp);
      chk("good_len", DW'(o_length), DW'(4));
    end
    idle(3, 1'b1);

    // Reset in the middle of a message, then a short message.
    msg = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    for (int i = 0; i < 5; i++) step(1'b1, msg[i], 1'b0, 1'b0, 16'h0, 1'b1);
    do_reset(2);
    msg = '{8'hA1, 8'hB2, 8'hC3};
    send(msg, 1'b1);
    chk("post_rst_len", DW'(o_length), DW'(3));
    chk("post_rst_data", o_data, {24'hA1B2C3, 392'h0});
    idle(3, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 1) == 1);
    end
    idle(20, 1'b1);
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
